// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi loopback frame controller.
package viterbi_pkg;

   typedef enum logic [2:0] {IDLE, DATA, TAIL, DRAIN, DONE} vfc_state_t;

   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
   localparam logic [1:0]  INJ_MASK          = 2'b01;

   // Galois-style tap mask B400 maps onto Fibonacci right-shift taps by bit reversal (bits 0,2,3,5).
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic [15:0] w_fib;
      for (int i = 0; i < 16; i++) w_fib[i] = LFSR_TAPS[15-i];
      return {^(s & w_fib), s[15:1]};
   endfunction

endpackage

// File: rtl/viterbi_lfsr16.sv
// 16-bit Fibonacci LFSR source; holds its state unless loaded or advanced.
module viterbi_lfsr16
   import viterbi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        advance,
   output logic        bit_o
);

   logic [15:0] r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         r_state <= LFSR_DEFAULT_SEED;
      else if (load)    r_state <= seed;
      else if (advance) r_state <= lfsr_step(r_state);
   end

   assign bit_o = r_state[0];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the encoder/decoder loopback: drives data and tail bits,
// schedules symbol error injection and counts decoded-bit mismatches.
module viterbi_frame_ctrl
   import viterbi_pkg::*;
#(
   parameter int FRAME_LEN = 256,
   parameter int TAIL_LEN  = 2,
   parameter int DEC_LAT   = 16,
   parameter int CW        = 16
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [15:0]   seed_i,
   input  logic [7:0]    err_period_i,
   output logic          enc_bit_o,
   output logic          enc_en_o,
   output logic [1:0]    err_inj_o,
   input  logic          dec_bit_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [CW-1:0] bit_err_ct_o,
   output logic [CW-1:0] inj_ct_o
);

   localparam int MAXV       = (FRAME_LEN > TAIL_LEN) ? ((FRAME_LEN > DEC_LAT) ? FRAME_LEN : DEC_LAT)
                                                      : ((TAIL_LEN > DEC_LAT) ? TAIL_LEN : DEC_LAT);
   localparam int PW         = $clog2(MAXV + 1);
   localparam int TAIL_LAST  = (TAIL_LEN > 0) ? TAIL_LEN - 1 : 0;
   // The last data bit reaches the tap DEC_LAT cycles after its DATA cycle, TAIL_LEN+1 of which precede DRAIN.
   localparam int DRAIN_LAST = (DEC_LAT > TAIL_LEN) ? DEC_LAT - TAIL_LEN - 1 : 0;

   vfc_state_t    r_state, w_state_next;
   logic [PW-1:0] r_phase;
   logic [7:0]    r_period, r_inj_cnt;
   logic [CW-1:0] r_err_ct, r_inj_ct;
   logic [DEC_LAT-1:0] r_dl_v, r_dl_b;
   logic [DEC_LAT:0]   w_dl_v_ext, w_dl_b_ext;

   logic w_enc_en, w_busy, w_done, w_last;
   logic w_start, w_lfsr_bit, w_in_v, w_inj_hit, w_tap_v, w_tap_b;
   logic [15:0] w_seed;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_enc_en     = 1'b0;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (start_i) w_state_next = DATA;
         end
         DATA: begin
            w_enc_en = 1'b1;
            w_last   = (r_phase == PW'(FRAME_LEN - 1));
            if (w_last) w_state_next = (TAIL_LEN == 0) ? DRAIN : TAIL;
         end
         TAIL: begin
            w_enc_en = 1'b1;
            w_last   = (r_phase == PW'(TAIL_LAST));
            if (w_last) w_state_next = DRAIN;
         end
         DRAIN: begin
            w_last = (r_phase == PW'(DRAIN_LAST));
            if (w_last) w_state_next = DONE;
         end
         DONE: begin
            w_done       = 1'b1;
            w_state_next = IDLE;
         end
         default: begin
            w_busy       = 1'b0;
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                     r_phase <= '0;
      else if (w_state_next != r_state)             r_phase <= '0;
      else if (r_state inside {DATA, TAIL, DRAIN})  r_phase <= r_phase + 1'b1;
   end

   assign w_start = (r_state == IDLE) && start_i;
   assign w_seed  = (seed_i == 16'h0000) ? LFSR_DEFAULT_SEED : seed_i;

   viterbi_lfsr16 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (w_start),
      .seed    (w_seed),
      .advance (r_state == DATA),
      .bit_o   (w_lfsr_bit)
   );

   assign w_in_v     = (r_state == DATA);
   assign w_dl_v_ext = {r_dl_v, w_in_v};
   assign w_dl_b_ext = {r_dl_b, w_in_v & w_lfsr_bit};
   assign w_tap_v    = r_dl_v[DEC_LAT-1];
   assign w_tap_b    = r_dl_b[DEC_LAT-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dl_v <= '0;
         r_dl_b <= '0;
      end else begin
         r_dl_v <= w_dl_v_ext[DEC_LAT-1:0];
         r_dl_b <= w_dl_b_ext[DEC_LAT-1:0];
      end
   end

   assign w_inj_hit = w_enc_en && (r_period != 8'd0) && (r_inj_cnt == r_period - 8'd1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_period  <= '0;
         r_inj_cnt <= '0;
         r_inj_ct  <= '0;
         r_err_ct  <= '0;
      end else if (w_start) begin
         r_period  <= err_period_i;
         r_inj_cnt <= '0;
         r_inj_ct  <= '0;
         r_err_ct  <= '0;
      end else begin
         if (w_enc_en && (r_period != 8'd0)) begin
            if (w_inj_hit) begin
               r_inj_cnt <= '0;
               if (r_inj_ct != {CW{1'b1}}) r_inj_ct <= r_inj_ct + 1'b1;
            end else begin
               r_inj_cnt <= r_inj_cnt + 1'b1;
            end
         end
         if (w_tap_v && (dec_bit_i != w_tap_b) && (r_err_ct != {CW{1'b1}}))
            r_err_ct <= r_err_ct + 1'b1;
      end
   end

   assign enc_en_o     = w_enc_en;
   assign enc_bit_o    = (r_state == DATA) & w_lfsr_bit;
   assign err_inj_o    = w_inj_hit ? INJ_MASK : 2'b00;
   assign busy_o       = w_busy;
   assign done_o       = w_done;
   assign bit_err_ct_o = r_err_ct;
   assign inj_ct_o     = r_inj_ct;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Loopback bench: an ideal (optionally inverting) decoder model feeds the controller;
// a scoreboard checks every encoder bit, every injection and every frame result.
module tb_viterbi_frame_ctrl;

   localparam int FRAME_LEN = 256;
   localparam int TAIL_LEN  = 2;
   localparam int DEC_LAT   = 16;
   localparam int CW        = 16;
   localparam int SAT_LEN   = 70000;
   // start cycle counts as cycle 1, then FRAME_LEN data cycles, DEC_LAT latency, one DONE cycle
   localparam int LAT_EXP   = 1 + FRAME_LEN + DEC_LAT + 1;

   typedef struct packed { logic b; logic inj; } bit_t;
   typedef struct { int err; int inj; int scyc; } res_t;

   logic clk = 1'b0;
   logic rst, start_i, dec_inv;
   logic [15:0] seed_i;
   logic [7:0]  err_period_i;
   logic enc_bit_o, enc_en_o, busy_o, done_o, dec_bit;
   logic [1:0] err_inj_o;
   logic [CW-1:0] bit_err_ct_o, inj_ct_o;

   logic s_rst, s_start, s_enc_bit, s_enc_en, s_busy, s_done, s_dec_bit;
   logic [15:0] s_seed;
   logic [7:0]  s_period;
   logic [1:0]  s_err_inj;
   logic [CW-1:0] s_err_ct, s_inj_ct;

   logic hist  [0:DEC_LAT];
   logic hist2 [0:DEC_LAT];
   bit_t bit_q[$];
   res_t exp_q[$];
   int n_err = 0, n_chk = 0, cyc = 0, frame_no = 0, s_en_cnt = 0, s_inj_cnt = 0;
   bit main_fin = 1'b0, sat_fin = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   viterbi_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .seed_i(seed_i), .err_period_i(err_period_i),
      .enc_bit_o(enc_bit_o), .enc_en_o(enc_en_o), .err_inj_o(err_inj_o), .dec_bit_i(dec_bit),
      .busy_o(busy_o), .done_o(done_o), .bit_err_ct_o(bit_err_ct_o), .inj_ct_o(inj_ct_o)
   );

   viterbi_frame_ctrl #(.FRAME_LEN(SAT_LEN), .TAIL_LEN(TAIL_LEN), .DEC_LAT(DEC_LAT), .CW(CW)) dut_sat (
      .clk(clk), .rst(s_rst), .start_i(s_start), .seed_i(s_seed), .err_period_i(s_period),
      .enc_bit_o(s_enc_bit), .enc_en_o(s_enc_en), .err_inj_o(s_err_inj), .dec_bit_i(s_dec_bit),
      .busy_o(s_busy), .done_o(s_done), .bit_err_ct_o(s_err_ct), .inj_ct_o(s_inj_ct)
   );

   // decoder model: returns the encoder bit of DEC_LAT cycles ago (sampled mid-cycle)
   always @(negedge clk) begin
      for (int i = DEC_LAT; i > 0; i--) begin
         hist[i]  <= hist[i-1];
         hist2[i] <= hist2[i-1];
      end
      hist[0]  <= enc_bit_o;
      hist2[0] <= s_enc_bit;
      if (s_enc_en) s_en_cnt <= s_en_cnt + 1;
      if (s_err_inj == 2'b01) s_inj_cnt <= s_inj_cnt + 1;
   end
   assign dec_bit   = hist[DEC_LAT] ^ dec_inv;
   assign s_dec_bit = ~hist2[DEC_LAT];

   function automatic logic [15:0] m_next(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst) begin
         if (enc_en_o) begin
            if (bit_q.size() == 0) check("unexpected enc_en", 1, 0);
            else begin
               bit_t e;
               e = bit_q.pop_front();
               check("enc_bit", {31'd0, enc_bit_o}, {31'd0, e.b});
               check("err_inj", {30'd0, err_inj_o}, e.inj ? 32'd1 : 32'd0);
            end
         end else begin
            check("err_inj idle", {30'd0, err_inj_o}, 0);
         end
         if (done_o) begin
            if (exp_q.size() == 0) check("unexpected done", 1, 0);
            else begin
               res_t r;
               r = exp_q.pop_front();
               frame_no++;
               $display("frame %0d: bit_err=%0d inj=%0d latency=%0d", frame_no, bit_err_ct_o, inj_ct_o, cyc - r.scyc + 1);
               check("bit_err_ct", {16'd0, bit_err_ct_o}, r.err);
               check("inj_ct", {16'd0, inj_ct_o}, r.inj);
               check("done latency", cyc - r.scyc + 1, LAT_EXP);
               check("leftover bits", bit_q.size(), 0);
            end
         end
      end
   end

   task automatic run_start(input logic [15:0] seed, input logic [7:0] p, input logic inv,
                            input int e_err, input int e_inj);
      logic [15:0] l;
      res_t r;
      @(posedge clk); #1;
      l = (seed == 16'h0000) ? 16'hACE1 : seed;
      for (int e = 0; e < FRAME_LEN + TAIL_LEN; e++) begin
         bit_t x;
         x.b   = (e < FRAME_LEN) ? l[0] : 1'b0;
         x.inj = (p != 8'd0) && (((e + 1) % int'(p)) == 0);
         if (e < FRAME_LEN) l = m_next(l);
         bit_q.push_back(x);
      end
      r.err = e_err; r.inj = e_inj; r.scyc = cyc;
      exp_q.push_back(r);
      dec_inv = inv; start_i = 1'b1; seed_i = seed; err_period_i = p;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < LAT_EXP + 50; i++) begin
         @(posedge clk); #1;
         if (done_o) begin seen = 1'b1; break; end
      end
      if (!seen) check({name, " done timeout"}, 0, 1);
   endtask

   task automatic check_all_zero(input string name);
      check({name, " enc_en"}, {31'd0, enc_en_o}, 0);
      check({name, " enc_bit"}, {31'd0, enc_bit_o}, 0);
      check({name, " err_inj"}, {30'd0, err_inj_o}, 0);
      check({name, " busy"}, {31'd0, busy_o}, 0);
      check({name, " done"}, {31'd0, done_o}, 0);
      check({name, " bit_err_ct"}, {16'd0, bit_err_ct_o}, 0);
      check({name, " inj_ct"}, {16'd0, inj_ct_o}, 0);
   endtask

   initial begin
      rst = 1'b0; start_i = 1'b0; seed_i = '0; err_period_i = '0; dec_inv = 1'b0;
      #12 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      run_start(16'h0001, 8'd0, 1'b0, 0, 0);
      wait_done("f1");
      @(posedge clk); #1 check("done single pulse", {31'd0, done_o}, 0);

      run_start(16'h1234, 8'd8, 1'b0, 0, 32);
      wait_done("f2");

      run_start(16'h0001, 8'd1, 1'b1, 256, 258);
      wait_done("f3");

      // abort in DATA cycle 100, between clock edges
      run_start(16'hBEEF, 8'd3, 1'b0, 0, 86);
      repeat (100) @(posedge clk);
      #1 rst = 1'b0;
      bit_q.delete();
      exp_q.delete();
      #1 check_all_zero("async reset");
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      run_start(16'hBEEF, 8'd3, 1'b0, 0, 86);
      wait_done("f4 restart");

      run_start(16'h00FF, 8'd0, 1'b0, 0, 0);
      repeat (50) @(posedge clk);
      #1 start_i = 1'b1; seed_i = 16'h5555; err_period_i = 8'd1;
      @(posedge clk); #1 start_i = 1'b0;
      check("busy after mid-frame start", {31'd0, busy_o}, 1);
      wait_done("f5");
      start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("idle after start on done", {31'd0, busy_o}, 0);
         @(posedge clk); #1;
      end

      run_start(16'h0000, 8'd0, 1'b0, 0, 0);
      check("zero seed first bit", {31'd0, enc_bit_o}, 1);
      wait_done("f6");
      main_fin = 1'b1;
   end

   initial begin
      bit seen = 1'b0;
      s_rst = 1'b0; s_start = 1'b0; s_seed = '0; s_period = '0;
      #32 s_rst = 1'b1;
      @(posedge clk); #1 s_start = 1'b1; s_seed = 16'h0001; s_period = 8'd1;
      @(posedge clk); #1 s_start = 1'b0;
      for (int i = 0; i < SAT_LEN + 200; i++) begin
         @(posedge clk); #1;
         if (s_done) begin seen = 1'b1; break; end
      end
      if (!seen) check("sat done timeout", 0, 1);
      $display("saturation frame: bit_err=%0h inj=%0h enabled=%0d", s_err_ct, s_inj_ct, s_en_cnt);
      check("sat bit_err_ct", {16'd0, s_err_ct}, 32'h0000FFFF);
      check("sat inj_ct", {16'd0, s_inj_ct}, 32'h0000FFFF);
      check("sat enabled cycles", s_en_cnt, SAT_LEN + TAIL_LEN);
      check("sat injected cycles", s_inj_cnt, SAT_LEN + TAIL_LEN);
      check("sat busy on done", {31'd0, s_busy}, 1);
      sat_fin = 1'b1;
   end

   initial begin
      wait (main_fin && sat_fin);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
